// File: rtl/divider_pkg.sv
// Shared types for the strobe divider family: monitor FSM states and counter widths.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    TRACK,
    LOCKED
  } monstate_t;

  // Width of the consecutive-match counter; caps LOCK_COUNT at 15.
  localparam int unsigned MatchW = 4;

endpackage

// File: rtl/strobe_rise_detect.sv
// Rising-edge detector for a strobe already synchronous to clk.
module strobe_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic rise
);

  logic strobe_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= strobe;
    end
  end

  // Cleared history makes a strobe held high across reset release count as one edge.
  assign rise = strobe & ~strobe_q;

endmodule

// File: rtl/strobe_period_monitor.sv
// Measures the edge-to-edge period of a one-cycle strobe, declares lock after
// LOCK_COUNT equal periods, and flags period changes and strobe loss.
module strobe_period_monitor
  import divider_pkg::*;
#(
  parameter int unsigned PW         = 8,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned MAX_PERIOD = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          strobe,
  output logic [PW-1:0] period,
  output logic          period_valid,
  output logic          locked,
  output logic          mismatch,
  output logic          timeout
);

  localparam logic [PW-1:0]     MaxCnt     = PW'(MAX_PERIOD);
  localparam logic [PW-1:0]     CntOne     = PW'(1);
  localparam logic [MatchW-1:0] MatchOne   = MatchW'(1);
  localparam logic [MatchW-1:0] LockTarget = MatchW'(LOCK_COUNT);
  localparam bit                LockOne    = (LOCK_COUNT == 1);

  logic              rise;
  logic [PW-1:0]     cnt;
  logic [PW-1:0]     ref_period;
  logic [MatchW-1:0] match_cnt;
  logic [MatchW-1:0] match_inc;
  logic              same;
  logic              expired;
  monstate_t         state;

  strobe_rise_detect u_rise (
    .clk    (clk),
    .reset  (reset),
    .strobe (strobe),
    .rise   (rise)
  );

  // cnt holds the number of cycles since the last edge, so it is the sample on an edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CntOne;
    end else if (cnt < MaxCnt) begin
      cnt <= cnt + CntOne;
    end
  end

  assign same      = (cnt == ref_period);
  assign match_inc = match_cnt + MatchOne;
  // An edge landing on the saturation cycle is a valid sample, not a loss.
  assign expired   = (state != IDLE) && (cnt == MaxCnt) && !rise;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      ref_period   <= '0;
      match_cnt    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      mismatch     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      timeout  <= 1'b0;
      if (expired) begin
        state        <= IDLE;
        timeout      <= 1'b1;
        period_valid <= 1'b0;
        locked       <= 1'b0;
        match_cnt    <= '0;
      end else if (rise) begin
        unique case (state)
          IDLE: begin
            state <= FIRST;
          end
          FIRST: begin
            ref_period   <= cnt;
            period       <= cnt;
            period_valid <= 1'b1;
            match_cnt    <= MatchOne;
            if (LockOne) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              state <= TRACK;
            end
          end
          TRACK: begin
            period <= cnt;
            if (same) begin
              match_cnt <= match_inc;
              if (match_inc == LockTarget) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              mismatch   <= 1'b1;
              ref_period <= cnt;
              match_cnt  <= MatchOne;
              if (LockOne) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
          end
          LOCKED: begin
            period <= cnt;
            if (!same) begin
              mismatch   <= 1'b1;
              ref_period <= cnt;
              match_cnt  <= MatchOne;
              // A single new period already satisfies a lock count of one.
              if (!LockOne) begin
                state  <= TRACK;
                locked <= 1'b0;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_strobe_period_monitor.sv
// Randomised and directed scoreboard bench for strobe_period_monitor.
module tb_strobe_period_monitor;

  localparam int unsigned PW   = 8;
  localparam int unsigned LC   = 4;
  localparam int unsigned MAXP = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          strobe = 1'b0;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          locked;
  logic          mismatch;
  logic          timeout;

  always #5 clk = ~clk;

  strobe_period_monitor #(
    .PW         (PW),
    .LOCK_COUNT (LC),
    .MAX_PERIOD (MAXP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .strobe       (strobe),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .mismatch     (mismatch),
    .timeout      (timeout)
  );

  typedef struct {
    int period;
    bit valid;
    bit locked;
    bit mismatch;
    bit timeout;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: edge timestamps and the run length of equal periods.
  int   cyc = 0;
  bit   m_prev = 0;
  bit   m_armed = 0;     // an edge has been seen since reset/timeout
  bit   m_have_ref = 0;  // at least one full period measured
  int   t_last = 0;
  int   m_ref = 0;
  int   m_run = 0;
  obs_t m_out = '{0, 0, 0, 0, 0};

  function automatic void model_step(bit rst_n, bit s);
    bit edge_seen;
    int p;
    cyc++;
    m_out.mismatch = 0;
    m_out.timeout  = 0;
    if (!rst_n) begin
      m_prev = 0; m_armed = 0; m_have_ref = 0; m_ref = 0; m_run = 0;
      m_out = '{0, 0, 0, 0, 0};
      return;
    end
    edge_seen = s && !m_prev;
    m_prev = s;
    if (edge_seen) begin
      if (m_armed) begin
        p = cyc - t_last;
        if (m_have_ref && p != m_ref) m_out.mismatch = 1;
        if (m_have_ref && p == m_ref) m_run++;
        else m_run = 1;
        m_ref = p;
        m_have_ref = 1;
        m_out.period = p;
        m_out.valid = 1;
        m_out.locked = (m_run >= LC);
      end
      m_armed = 1;
      t_last = cyc;
    end else if (m_armed && (cyc - t_last) == MAXP) begin
      m_armed = 0; m_have_ref = 0; m_run = 0;
      m_out.timeout = 1;
      m_out.valid = 0;
      m_out.locked = 0;
    end
  endfunction

  task automatic tick(bit rst_n, bit s);
    @(negedge clk);
    reset  = rst_n;
    strobe = s;
    @(posedge clk);
    model_step(rst_n, s);
    exp_q.push_back(m_out);
  endtask

  // One strobe period: high for w cycles, low for the rest.
  task automatic pulse_w(int per, int w);
    for (int i = 0; i < per; i++) tick(1'b1, i < w);
  endtask

  task automatic train(int per, int n);
    for (int i = 0; i < n; i++) pulse_w(per, 1);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("period", 32'(period), 32'(e.period));
        chk("period_valid", 32'(period_valid), 32'(e.valid));
        chk("locked", 32'(locked), 32'(e.locked));
        chk("mismatch", 32'(mismatch), 32'(e.mismatch));
        chk("timeout", 32'(timeout), 32'(e.timeout));
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int per;
    int w;
    repeat (3) tick(1'b0, 1'b0);

    // Divide-by-3 lock.
    train(3, 8);
    // Stretched period, then return and re-lock.
    pulse_w(4, 1);
    train(3, 8);
    // Strobe lost while locked.
    repeat (300) tick(1'b1, 1'b0);
    // Strobe held high across reset release.
    repeat (2) tick(1'b0, 1'b1);
    repeat (300) tick(1'b1, 1'b1);
    repeat (4) tick(1'b1, 1'b0);
    // Edge exactly on the saturation cycle.
    train(3, 3);
    train(MAXP, 5);
    train(3, 6);
    // Reset mid-lock, then re-lock.
    tick(1'b0, 1'b0);
    train(3, 8);

    // Randomised periods, widths, occasional resets and dropouts.
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 9))
        0: per = $urandom_range(2, 20);
        1: per = 2;
        2: per = 5;
        default: per = 3;
      endcase
      w = $urandom_range(1, per - 1);
      if ($urandom_range(0, 29) == 0) tick(1'b0, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 39) == 0) repeat ($urandom_range(250, 260)) tick(1'b1, 1'b0);
      for (int r = 0; r < int'($urandom_range(1, 6)); r++) pulse_w(per, w);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/strobe_period_monitor.md
Name: strobe_period_monitor

Overview:
- Receive-side companion to the team's divide-by-N strobe generators.
- Takes a periodic one-cycle-wide strobe, measures the rising-edge-to-rising-edge period in clk cycles, and declares lock after LOCK_COUNT consecutive identical periods.
- Flags period mismatches and strobe loss (timeout).
- Used as a self-check/monitor beside clock-enable dividers.

Parameters:
- PW, 8, width of the cycle counter and the period output.
- LOCK_COUNT, 4, consecutive equal periods required to assert locked (legal range 1..15).
- MAX_PERIOD, 255, cycle count with no rising edge that triggers timeout (must be ≤ 2^PW-1 and ≥ 2).

Ports:
- clk  input  1  single clock; all flops rising-edge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- strobe  input  1  monitored strobe, synchronous to clk.
- period  output  PW  last measured period in cycles.
- period_valid  output  1  period holds a real measurement.
- locked  output  1  LOCK_COUNT consecutive equal periods seen, and none different since.
- mismatch  output  1  one-cycle pulse when a measured period differs from the tracked reference.
- timeout  output  1  one-cycle pulse when no edge arrives within MAX_PERIOD cycles while not IDLE.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, strobe_q=0, cnt=0, ref=0, match_cnt=0.
  - Outputs: period=0, period_valid=0, locked=0, mismatch=0, timeout=0.
  - Reset mid-operation discards everything; there is no partial state.
- Edge detection: edge = strobe & ~strobe_q, with strobe_q registered each cycle.
  - A strobe already high when reset releases counts as an edge in the first active cycle.
  - A constantly high strobe gives one edge only.
- Counter: on an edge cycle cnt<=1. Otherwise cnt<=cnt+1, saturating at MAX_PERIOD.
  - sample = cnt, taken in the edge cycle. Example: edges 3 cycles apart give sample=3.
- All outputs are registered. Effects of an edge at cycle t are visible at cycle t+1.
- States:
  - IDLE: waiting for the first edge. edge -> FIRST. No timeout is generated in IDLE.
  - FIRST: on edge:
    - ref<=sample, period<=sample, period_valid<=1, match_cnt<=1.
    - Go to LOCKED if LOCK_COUNT==1, else TRACK.
  - TRACK: on edge with sample==ref: match_cnt<=match_cnt+1, period<=sample.
    - If match_cnt+1==LOCK_COUNT, go to LOCKED and set locked<=1.
  - TRACK: on edge with sample!=ref:
    - mismatch pulse, ref<=sample, period<=sample, match_cnt<=1, stay in TRACK.
    - If LOCK_COUNT==1, go to LOCKED instead.
  - LOCKED: edge with sample==ref: period refresh only.
  - LOCKED: edge with sample!=ref: mismatch pulse, locked<=0, ref<=sample, match_cnt<=1, go to TRACK.
- Timeout applies in FIRST, TRACK and LOCKED. It fires when cnt==MAX_PERIOD and there is no edge that cycle. Next cycle:
  - timeout=1, state=IDLE, period_valid=0, locked=0, match_cnt=0.
  - period keeps its last value.
- Simultaneous edge and cnt==MAX_PERIOD: the edge wins. It is processed normally with sample=MAX_PERIOD, and there is no timeout.
- mismatch and timeout are never asserted in the same cycle. Each is high for exactly one cycle per event.
- Width rule: match_cnt is 4 bits. All comparisons are unsigned. cnt never wraps because it saturates.

Decomposition:
- Shared package divider_pkg:
  - typedef enum logic[1:0] {IDLE, FIRST, TRACK, LOCKED} monstate_t.
  - localparam for the match_cnt width (4).
- One natural sub-module: strobe_rise_detect. It holds the strobe_q register and the edge output, and has the same clk and reset.
- Everything else stays in the top: counter, FSM and output registers.

Test Plan:
1. Reset, then a divide-by-3 strobe (high 1 of every 3 cycles), LOCK_COUNT=4.
   - period=3 and period_valid=1 one cycle after the 2nd edge.
   - locked=1 one cycle after the 5th edge.
   - mismatch never pulses.
2. While locked, stretch one period to 4 cycles.
   - Required: a single mismatch pulse, locked drops, period=4.
   - Returning to period 3 gives another mismatch and a re-lock after 4 more equal periods.
3. While locked, hold strobe low.
   - Required: a timeout pulse exactly MAX_PERIOD=255 cycles after the last edge's cnt<=1 cycle.
   - Then locked=0, period_valid=0, period still 3, and no further timeouts.
4. Hold strobe high through reset release.
   - Required: one edge, state FIRST, and a timeout 255 cycles later, then IDLE.
5. Send an edge exactly when cnt==MAX_PERIOD.
   - Required: no timeout, and period=255 accepted as a sample.
6. Assert reset for one cycle mid-lock.
   - Required: every output returns to 0 next cycle, and re-lock follows the scenario 1 timing from the next edge.
